// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory controller.
//   dmem_state_t     : controller FSM state encoding
//   DEPTH_WORDS_DEF  : default number of 32-bit words in the data memory
//   WAIT_CYCLES_DEF  : default number of wait states per access (0..15)
//   CNT_W            : width of the wait-state down-counter
//   addr_bits()      : word-index width for a given memory depth
package mem_pkg;

    localparam int DEPTH_WORDS_DEF = 256;
    localparam int WAIT_CYCLES_DEF = 2;
    localparam int CNT_W           = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } dmem_state_t;

    // A one-word memory still needs a 1-bit index.
    function automatic int addr_bits(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port data memory, synchronous write and synchronous read, no reset.
//   clk   : clock
//   we    : write enable, stores wdata at addr on the rising edge
//   re    : read enable, loads rdata from addr on the rising edge
//   addr  : word index
//   wdata : store data
//   rdata : read data, holds its value while re is low
module dmem_ram #(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: validates load/store requests, inserts WAIT_CYCLES
// wait states, performs the access on dmem_ram and pulses ready on completion.
//   clk      : clock
//   rst      : asynchronous active-high reset
//   MemRd    : read request
//   MemWr    : write request
//   addr     : byte address
//   wdata    : store data
//   rdata    : load data, holds until the next read completes
//   stall    : pipeline hold while an access is pending
//   ready    : one-cycle completion pulse
//   addr_err : one-cycle pulse after a rejected request
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for a request; valid ones are captured and accepted
// WAIT  | counting down wait states; access happens as count leaves 1
// DONE  | access complete, ready high; requests ignored
module dmem_ctrl
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = DEPTH_WORDS_DEF,
    parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRd,
    input  logic        MemWr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        ready,
    output logic        addr_err
);

    localparam int               AW      = addr_bits(DEPTH_WORDS);
    localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WAIT_CYCLES);

    dmem_state_t      state;
    logic [CNT_W-1:0] cnt;
    logic [AW-1:0]    cap_idx;
    logic [31:0]      cap_wdata;
    logic             cap_wr;
    logic             rdata_vld;

    logic             aligned;
    logic             in_range;
    logic             valid;
    logic             reject;

    logic [AW-1:0]    ram_idx;
    logic [31:0]      ram_wdata;
    logic             ram_we;
    logic             ram_re;
    logic [31:0]      ram_rdata;

    assign aligned  = (addr[1:0] == 2'b00);
    assign in_range = ({2'b00, addr[31:2]} < 32'(DEPTH_WORDS));
    assign valid    = (state == IDLE) && (MemRd ^ MemWr) && aligned && in_range;
    assign reject   = (state == IDLE) && (MemRd | MemWr) && !valid;
    assign stall    = valid || (state == WAIT);

    // With zero wait states the access happens on the accepting edge, so the
    // RAM is driven straight from the request; otherwise from the captured copy.
    always_comb begin
        ram_idx   = cap_idx;
        ram_wdata = cap_wdata;
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        if (WAIT_CYCLES == 0) begin
            ram_idx   = addr[AW+1:2];
            ram_wdata = wdata;
            ram_we    = valid && MemWr;
            ram_re    = valid && MemRd;
        end else if ((state == WAIT) && (cnt == CNT_W'(1))) begin
            ram_we = cap_wr;
            ram_re = !cap_wr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            cap_idx   <= '0;
            cap_wdata <= '0;
            cap_wr    <= 1'b0;
            rdata_vld <= 1'b0;
            ready     <= 1'b0;
            addr_err  <= 1'b0;
        end else begin
            ready    <= 1'b0;
            addr_err <= reject;
            case (state)
                IDLE: begin
                    if (valid) begin
                        cap_idx   <= addr[AW+1:2];
                        cap_wdata <= wdata;
                        cap_wr    <= MemWr;
                        if (WAIT_CYCLES == 0) begin
                            state <= DONE;
                            ready <= 1'b1;
                            if (MemRd) begin
                                rdata_vld <= 1'b1;
                            end
                        end else begin
                            cnt   <= WAIT_LD;
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= DONE;
                        ready <= 1'b1;
                        if (!cap_wr) begin
                            rdata_vld <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // The RAM output register has no reset; rdata reads as zero until the
    // first read after reset completes, then follows the RAM output, which
    // only changes on a read access.
    assign rdata = rdata_vld ? ram_rdata : 32'h0;

    dmem_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (ram_idx),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: one instance with two wait states, one with none.
module tb_dmem_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        rd, wr;
    logic [31:0] a, wd;
    logic [31:0] rdata;
    logic        stall, ready, aerr;

    logic        rd0, wr0;
    logic [31:0] a0, wd0;
    logic [31:0] rdata0;
    logic        stall0, ready0, aerr0;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    dmem_ctrl #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .MemRd    (rd),
        .MemWr    (wr),
        .addr     (a),
        .wdata    (wd),
        .rdata    (rdata),
        .stall    (stall),
        .ready    (ready),
        .addr_err (aerr)
    );

    dmem_ctrl #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) u_dut0 (
        .clk      (clk),
        .rst      (rst),
        .MemRd    (rd0),
        .MemWr    (wr0),
        .addr     (a0),
        .wdata    (wd0),
        .rdata    (rdata0),
        .stall    (stall0),
        .ready    (ready0),
        .addr_err (aerr0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic drive(input logic r, input logic w, input logic [31:0] ad, input logic [31:0] d);
        rd = r;
        wr = w;
        a  = ad;
        wd = d;
    endtask

    // Full access on the two-wait-state instance. During the wait cycles the
    // inputs carry a different address, data and opposite operation, which
    // must not affect the access in progress. {stall,ready}: 2 = stall, 1 = ready.
    task automatic acc2(input logic w, input logic [31:0] ad, input logic [31:0] d, input string tag);
        nxt();
        drive(~w, w, ad, d);
        smp();
        chk({tag, "_req"}, {30'b0, stall, ready}, 32'h2);
        for (int i = 1; i <= 2; i++) begin
            nxt();
            drive(w, ~w, ad ^ 32'h40, ~d);
            smp();
            chk($sformatf("%s_wait%0d", tag, i), {30'b0, stall, ready}, 32'h2);
        end
        nxt();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        smp();
        chk({tag, "_done"}, {30'b0, stall, ready}, 32'h1);
    endtask

    task automatic reject2(input logic r, input logic w, input logic [31:0] ad, input string tag);
        nxt();
        drive(r, w, ad, 32'h1111_1111);
        smp();
        chk({tag, "_stall"}, {31'b0, stall}, 32'h0);
        nxt();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        smp();
        chk({tag, "_err"}, {31'b0, aerr}, 32'h1);
        chk({tag, "_rdy"}, {31'b0, ready}, 32'h0);
        nxt();
        smp();
        chk({tag, "_errclr"}, {31'b0, aerr}, 32'h0);
    endtask

    initial begin
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        rd0 = 1'b0;
        wr0 = 1'b0;
        a0  = 32'h0;
        wd0 = 32'h0;

        smp();
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_stall", {31'b0, stall}, 32'h0);
        chk("rst_ready", {31'b0, ready}, 32'h0);
        chk("rst_err", {31'b0, aerr}, 32'h0);
        chk("rst_rdata0", rdata0, 32'h0);
        nxt();
        nxt();
        rst = 1'b0;

        acc2(1'b1, 32'h10, 32'hDEAD_BEEF, "wr10");
        acc2(1'b0, 32'h10, 32'h0, "rd10");
        chk("rd10_data", rdata, 32'hDEAD_BEEF);

        reject2(1'b1, 1'b0, 32'h13, "mis");
        reject2(1'b1, 1'b0, 32'h400, "oor");
        chk("err_rdata", rdata, 32'hDEAD_BEEF);

        acc2(1'b1, 32'h3FC, 32'hCAFE_F00D, "wr3fc");
        acc2(1'b0, 32'h3FC, 32'h0, "rd3fc");
        chk("rd3fc_data", rdata, 32'hCAFE_F00D);

        reject2(1'b1, 1'b1, 32'h10, "both");
        acc2(1'b0, 32'h10, 32'h0, "rd10b");
        chk("rd10b_data", rdata, 32'hDEAD_BEEF);

        // Reset in the first wait cycle of a write over a known zero word.
        acc2(1'b1, 32'h20, 32'h0, "wr20z");
        nxt();
        drive(1'b0, 1'b1, 32'h20, 32'h1234_5678);
        smp();
        chk("wr20_stall", {31'b0, stall}, 32'h1);
        nxt();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        rst = 1'b1;
        smp();
        chk("mid_stall", {31'b0, stall}, 32'h0);
        chk("mid_ready", {31'b0, ready}, 32'h0);
        chk("mid_rdata", rdata, 32'h0);
        chk("mid_err", {31'b0, aerr}, 32'h0);
        nxt();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            nxt();
            smp();
            chk($sformatf("post_rst%0d", i), {30'b0, stall, ready}, 32'h0);
        end
        acc2(1'b0, 32'h20, 32'h0, "rd20");
        chk("rd20_data", rdata, 32'h0);

        // Zero wait states: stall only in the request cycle, ready the next.
        nxt();
        wr0 = 1'b1;
        a0  = 32'h8;
        wd0 = 32'hA5A5_A5A5;
        smp();
        chk("z_wr_req", {30'b0, stall0, ready0}, 32'h2);
        nxt();
        wr0 = 1'b0;
        a0  = 32'h0;
        wd0 = 32'h0;
        smp();
        chk("z_wr_done", {30'b0, stall0, ready0}, 32'h1);
        nxt();
        rd0 = 1'b1;
        a0  = 32'h8;
        smp();
        chk("z_rd_req", {30'b0, stall0, ready0}, 32'h2);
        nxt();
        rd0 = 1'b0;
        a0  = 32'h0;
        smp();
        chk("z_rd_done", {30'b0, stall0, ready0}, 32'h1);
        chk("z_rd_data", rdata0, 32'hA5A5_A5A5);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameter DEPTH_WORDS, default 256, SHALL set the number of 32-bit words in the data memory.
REQ-003 Parameter WAIT_CYCLES, default 2, range 0..15, SHALL set the number of wait states per access.
REQ-004 Port clk, input, 1 bit: clock; all state SHALL update on the rising edge.
REQ-005 Port rst, input, 1 bit: asynchronous active-high reset.
REQ-006 Port MemRd, input, 1 bit: read request from the main control unit.
REQ-007 Port MemWr, input, 1 bit: write request from the main control unit.
REQ-008 Port addr, input, 32 bits: byte address from the ALU result.
REQ-009 Port wdata, input, 32 bits: store data.
REQ-010 Port rdata, output, 32 bits: registered load data.
REQ-011 Port stall, output, 1 bit: pipeline hold while an access is pending.
REQ-012 Port ready, output, 1 bit: one-cycle completion pulse.
REQ-013 Port addr_err, output, 1 bit: one-cycle pulse for a rejected request.

Function
REQ-014 The FSM SHALL have three states: IDLE, WAIT and DONE.
REQ-015 A valid request SHALL be MemRd XOR MemWr in IDLE, with addr[1:0]==0 and addr[31:2] < DEPTH_WORDS.
REQ-016 In IDLE, a valid request SHALL capture addr, wdata and the operation, load the counter with WAIT_CYCLES, and move to WAIT, or straight to DONE if WAIT_CYCLES==0.
REQ-017 In WAIT, the counter SHALL decrement every cycle; on the edge where it leaves 1, the access SHALL be performed and the FSM SHALL enter DONE.
REQ-018 A write SHALL commit the captured wdata to the word at captured addr[31:2] exactly at the access edge.
REQ-019 A read SHALL load rdata at the access edge, and rdata SHALL hold that value until the next read completes.
REQ-020 Stall SHALL equal (IDLE and valid request) OR WAIT, combinationally, so the pipeline holds from the request cycle onward.
REQ-021 For a request accepted in cycle t: stall SHALL be high in cycles t..t+WAIT_CYCLES, ready SHALL be high only in cycle t+WAIT_CYCLES+1, and stall SHALL be low in that cycle.
REQ-022 DONE SHALL always return to IDLE after one cycle, and MemRd/MemWr SHALL be ignored while in DONE.
REQ-023 In IDLE, MemRd and MemWr both high SHALL pulse addr_err for one cycle, perform no access, assert no stall and stay in IDLE.
REQ-024 A request that is misaligned or out of range SHALL pulse addr_err for one cycle, perform no access, assert no stall and stay in IDLE.
REQ-025 Inputs that change during WAIT SHALL NOT affect the access in progress.
REQ-026 Back-to-back accesses SHALL be supported, with the next request accepted in the IDLE cycle right after DONE; a read after a write to the same word SHALL return the new data.

Reset
REQ-027 Reset SHALL force state=IDLE, counter=0, rdata=0, stall=0, ready=0 and addr_err=0 immediately.
REQ-028 Reset before the access edge SHALL discard the pending access, and memory contents SHALL NOT be reset or altered.

Structure
REQ-029 The state enum dmem_state_t and the WAIT_CYCLES/DEPTH_WORDS defaults SHALL live in shared package mem_pkg.
REQ-030 The storage array SHALL be a sub-module dmem_ram: single-port, synchronous write, synchronous read, with no reset.

Verification
REQ-031 With WAIT_CYCLES=2, write 0xDEADBEEF to addr 0x10 at cycle 0, then read 0x10 -> stall high in cycles 0-2, ready in cycle 3, and the read returns rdata=0xDEADBEEF with ready in cycle 7.
REQ-032 With WAIT_CYCLES=0, issue a read -> stall high for exactly one cycle, and ready plus valid rdata in the next cycle.
REQ-033 Read addr 0x13, then addr 0x400 with DEPTH_WORDS=256 -> addr_err pulses each time, with no stall, no ready, and rdata unchanged.
REQ-034 Assert MemRd=MemWr=1 -> one addr_err pulse and memory unchanged.
REQ-035 Issue a write of 0x12345678 to 0x20 over old value 0x0 and assert rst in the first WAIT cycle -> outputs are 0 at once, and a later read of 0x20 returns 0x0.
REQ-036 Change addr/wdata during WAIT -> the original captured values are used.
